bcd_counter: RTL and testbench
==============================

# bcd_counter

Parametrised multi-digit synchronous BCD counter, the successor to the single-digit decade counter. It counts up or down over DIGITS decimal digits, with enable, parallel load and synchronous reset. It exposes a combinational terminal-count output for cascading and a registered wrap pulse for event logging. It drives seven-segment display paths and timekeeping logic on the board.

## Interface
- DIGITS, default 4: number of BCD digits; legal range 1..8.
- CLK  input  1  system clock; all state changes on its rising edge.
- RST  input  1  synchronous, active-high reset.
- EN  input  1  count enable; one step per CLK edge while high.
- UP  input  1  direction: 1 = increment, 0 = decrement; sampled every cycle.
- LOAD  input  1  parallel load strobe.
- LOAD_VAL  input  4*DIGITS  load value; digit i is bits [4i+3:4i], digit 0 is least significant.
- COUNT  output  4*DIGITS  registered BCD count, same digit packing.
- TC  output  1  combinational terminal count, for cascading.
- WRAP  output  1  registered one-cycle pulse, high the cycle after the count wrapped.

## Operation
- Priority per edge: RST, then LOAD, then EN, then hold.
- RST: COUNT set to 0 and WRAP set to 0. LOAD, EN and UP are ignored that cycle.
- LOAD: each digit takes its LOAD_VAL nibble. A nibble greater than 9 is loaded as 9.
  - No counting happens on a load cycle, even if EN is high.
  - WRAP is 0 on the cycle after a load.
- EN with UP=1:
  - Digit 0 increments. 9 becomes 0.
  - Digit i increments only when digits 0..i-1 are all 9.
- EN with UP=0:
  - Digit 0 decrements. 0 becomes 9.
  - Digit i decrements only when digits 0..i-1 are all 0.
- Wrap-around:
  - Up from all-9s (for example 9999) goes to 0000.
  - Down from 0000 goes to all-9s.
  - No saturation, no sticky flag.
- TC = EN & ~LOAD & ~RST & (UP ? all digits 9 : all digits 0). It is high exactly in the cycle whose edge causes a wrap.
- WRAP: registered copy of TC.
- Direction change while EN is high takes effect on the same edge; there is no pipeline to flush.
- Invariant: every digit of COUNT is always in 0..9. No reachable state holds a nibble of A–F.
- Cascading: chain TC of one instance into EN of the next, sharing UP. Every instance in the chain must be driven by the same CLK.

## Timing
- COUNT: registered, updates on the CLK edge where RST, LOAD or EN is active. Latency is one cycle from the input to the new value.
- TC: purely combinational from EN, LOAD, RST, UP and the current COUNT. There is no register stage.
- WRAP: one-cycle pulse, asserted in the cycle after the wrapping edge.
- Reset values: COUNT = 0, WRAP = 0. TC follows its equation and is 0 while RST is high.
- Reset mid-count overrides any in-progress carry or borrow. The next non-reset edge starts from 0.
- Simultaneous LOAD and EN: the load wins, the count does not advance, and TC is 0.
- The ripple of digit-enable terms across DIGITS digits is combinational within one cycle. For DIGITS ≤ 8 it needs no extra pipelining.

## Structure
- Shared package holds:
  - the BCD digit width constant (4);
  - the maximum digit constant (9);
  - the legal DIGITS range, used by the elaboration-time check.
- Sub-module bcd_digit: one decade digit with CLK, RST, LOAD, load nibble (already clamped), step enable and UP.
  - Outputs: its 4-bit value, at_max (value is 9) and at_min (value is 0).
- Top-level bcd_counter:
  - instantiates DIGITS bcd_digit copies in a generate loop;
  - builds the step enable for each digit from the lower digits' at_max or at_min flags;
  - clamps load nibbles;
  - forms TC and WRAP.
- Elaboration-time check rejects DIGITS outside 1..8.

## Test plan
- Reset: RST=1 for 2 cycles with EN=1 and LOAD=1, DIGITS=4 → COUNT=0000, WRAP=0, TC=0; after release with EN=1, UP=1 → COUNT=0001 one edge later.
- Up carry: load 0199, EN=1, UP=1 → 0200 after one edge; load 9998 → 9999 with TC=1, then 0000 with WRAP=1 for exactly one cycle.
- Down borrow: load 1000, EN=1, UP=0 → 0999; load 0001 → 0000 with TC=1, then 9999 with WRAP=1.
- Load handling: LOAD_VAL=16'hA5F3 with LOAD=1, EN=1 → COUNT=9593, no count step, WRAP=0 next cycle.
- Direction flip: from 0009, UP=1 for one edge → 0010; UP=0 next edge → 0009; EN=0 for 3 cycles → COUNT holds at 0009.
- Cascade: two DIGITS=2 instances, the lower TC driving the upper EN, lower loaded to 99 and upper to 05, UP=1 → after one edge the lower is 00 and the upper is 06.

Source files
------------

// File: rtl/bcd_counter_pkg.sv
// Shared constants and helpers for the multi-digit BCD counter.
// Holds the digit width, the largest decimal digit and the legal DIGITS range.
package bcd_counter_pkg;

  localparam int         BCD_W      = 4;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         DIGITS_MIN = 1;
  localparam int         DIGITS_MAX = 8;

  // Nibbles A-F from the load bus become 9 so no digit ever leaves 0..9.
  function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

endpackage

// File: rtl/bcd_counter_digit.sv
// One decade digit: synchronous reset, load, and up/down step with 9<->0 wrap.
// Reports at_max/at_min so the parent can ripple carry and borrow enables.
module bcd_digit
  import bcd_counter_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD,
  input  logic [BCD_W-1:0] load_nib,
  input  logic             step,
  input  logic             UP,
  output logic [BCD_W-1:0] value,
  output logic             at_max,
  output logic             at_min
);

  logic [BCD_W-1:0] value_q;
  logic [BCD_W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (LOAD) begin
      value_d = load_nib;
    end else if (step) begin
      if (UP) begin
        value_d = (value_q == BCD_MAX) ? '0 : value_q + 4'd1;
      end else begin
        value_d = (value_q == '0) ? BCD_MAX : value_q - 4'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value  = value_q;
  assign at_max = (value_q == BCD_MAX);
  assign at_min = (value_q == '0);

endmodule

// File: rtl/bcd_counter.sv
// Multi-digit synchronous up/down BCD counter with load, a combinational
// terminal count for cascading and a registered one-cycle wrap pulse.
module bcd_counter
  import bcd_counter_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    EN,
  input  logic                    UP,
  input  logic                    LOAD,
  input  logic [BCD_W*DIGITS-1:0] LOAD_VAL,
  output logic [BCD_W*DIGITS-1:0] COUNT,
  output logic                    TC,
  output logic                    WRAP
);

  if (DIGITS < DIGITS_MIN || DIGITS > DIGITS_MAX) begin : g_bad_digits
    $error("bcd_counter: DIGITS=%0d outside legal range %0d..%0d",
           DIGITS, DIGITS_MIN, DIGITS_MAX);
  end

  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic              tc_d;
  logic              wrap_q;
  logic              wrap_d;

  // Digit i steps only when every lower digit is at its wrap point.
  always_comb begin
    step[0] = EN & ~LOAD;
    for (int i = 1; i < DIGITS; i++) begin
      step[i] = step[i-1] & (UP ? at_max[i-1] : at_min[i-1]);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .CLK      (CLK),
      .RST      (RST),
      .LOAD     (LOAD),
      .load_nib (clamp_bcd(LOAD_VAL[BCD_W*g +: BCD_W])),
      .step     (step[g]),
      .UP       (UP),
      .value    (COUNT[BCD_W*g +: BCD_W]),
      .at_max   (at_max[g]),
      .at_min   (at_min[g])
    );
  end

  always_comb begin
    tc_d   = EN & ~LOAD & ~RST & (UP ? (&at_max) : (&at_min));
    wrap_d = tc_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign TC   = tc_d;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_bcd_counter.sv
// Directed bench for bcd_counter: a 4-digit instance plus a cascaded
// pair of 2-digit instances, expectations written out by hand.
module tb_bcd_counter;

  logic        clk;
  logic        rst, en, up, load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        tc, wrap;

  logic        c_load, c_en, c_up;
  logic [7:0]  lo_lv, hi_lv, lo_cnt, hi_cnt;
  logic        lo_tc, lo_wrap, hi_tc, hi_wrap;

  int n_vec = 0;
  int n_err = 0;

  bcd_counter #(.DIGITS(4)) dut (
    .CLK(clk), .RST(rst), .EN(en), .UP(up), .LOAD(load),
    .LOAD_VAL(load_val), .COUNT(count), .TC(tc), .WRAP(wrap)
  );

  bcd_counter #(.DIGITS(2)) u_lo (
    .CLK(clk), .RST(rst), .EN(c_en), .UP(c_up), .LOAD(c_load),
    .LOAD_VAL(lo_lv), .COUNT(lo_cnt), .TC(lo_tc), .WRAP(lo_wrap)
  );

  bcd_counter #(.DIGITS(2)) u_hi (
    .CLK(clk), .RST(rst), .EN(lo_tc), .UP(c_up), .LOAD(c_load),
    .LOAD_VAL(hi_lv), .COUNT(hi_cnt), .TC(hi_tc), .WRAP(hi_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b1; load_val = 16'h1234;
    c_load = 1'b0; c_en = 1'b0; c_up = 1'b1; lo_lv = 8'h00; hi_lv = 8'h00;

    // Reset held two cycles with LOAD and EN active
    tick();
    chk("rst1_count", count, 16'h0000);
    chk("rst1_wrap", {15'd0, wrap}, 16'd0);
    chk("rst1_tc", {15'd0, tc}, 16'd0);
    tick();
    chk("rst2_count", count, 16'h0000);
    chk("rst2_wrap", {15'd0, wrap}, 16'd0);
    chk("rst2_tc", {15'd0, tc}, 16'd0);

    rst = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
    #1;
    chk("rel_tc", {15'd0, tc}, 16'd0);
    tick();
    chk("rel_count", count, 16'h0001);

    // Up carry across two digits
    load = 1'b1; load_val = 16'h0199;
    tick();
    chk("ld0199", count, 16'h0199);
    load = 1'b0;
    tick();
    chk("up0200", count, 16'h0200);

    // Up wrap from 9999
    load = 1'b1; load_val = 16'h9998;
    tick();
    chk("ld9998", count, 16'h9998);
    load = 1'b0;
    #1;
    chk("tc9998", {15'd0, tc}, 16'd0);
    tick();
    chk("up9999", count, 16'h9999);
    chk("tc9999", {15'd0, tc}, 16'd1);
    chk("wrap_pre", {15'd0, wrap}, 16'd0);
    tick();
    chk("up0000", count, 16'h0000);
    chk("wrap_up", {15'd0, wrap}, 16'd1);
    chk("tc0000up", {15'd0, tc}, 16'd0);
    en = 1'b0;
    tick();
    chk("wrap_up_end", {15'd0, wrap}, 16'd0);
    chk("hold0000", count, 16'h0000);

    // Down borrow and down wrap
    load = 1'b1; load_val = 16'h1000;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    chk("dn0999", count, 16'h0999);
    load = 1'b1; load_val = 16'h0001;
    tick();
    load = 1'b0;
    tick();
    chk("dn0000", count, 16'h0000);
    chk("tc_dn", {15'd0, tc}, 16'd1);
    tick();
    chk("dn9999", count, 16'h9999);
    chk("wrap_dn", {15'd0, wrap}, 16'd1);

    // Load clamps A-F nibbles and beats EN even at terminal count
    up = 1'b1; load = 1'b1; load_val = 16'hA5F3;
    #1;
    chk("tc_load", {15'd0, tc}, 16'd0);
    tick();
    chk("ldA5F3", count, 16'h9593);
    chk("wrap_ld", {15'd0, wrap}, 16'd0);
    load = 1'b0; en = 1'b0;
    tick();
    chk("wrap_after_ld", {15'd0, wrap}, 16'd0);
    chk("hold9593", count, 16'h9593);

    // Direction flip then hold
    load = 1'b1; load_val = 16'h0009;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    chk("flip_up", count, 16'h0010);
    up = 1'b0;
    tick();
    chk("flip_dn", count, 16'h0009);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold0009", count, 16'h0009);
    end

    // Reset mid-count, then restart from zero
    en = 1'b1; up = 1'b1; rst = 1'b1;
    tick();
    chk("midrst", count, 16'h0000);
    rst = 1'b0;
    tick();
    chk("post_midrst", count, 16'h0001);
    en = 1'b0;

    // Cascade of two 2-digit instances
    c_load = 1'b1; lo_lv = 8'h99; hi_lv = 8'h05; c_en = 1'b0; c_up = 1'b1;
    tick();
    chk("casc_ld_lo", {8'd0, lo_cnt}, 16'h0099);
    chk("casc_ld_hi", {8'd0, hi_cnt}, 16'h0005);
    c_load = 1'b0; c_en = 1'b1;
    #1;
    chk("casc_lo_tc", {15'd0, lo_tc}, 16'd1);
    tick();
    chk("casc_lo", {8'd0, lo_cnt}, 16'h0000);
    chk("casc_hi", {8'd0, hi_cnt}, 16'h0006);
    chk("casc_lo_wrap", {15'd0, lo_wrap}, 16'd1);
    c_en = 1'b0;
    tick();
    chk("casc_hold_hi", {8'd0, hi_cnt}, 16'h0006);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
